dmem_arbiter: RTL



---
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response channel between one requester and the data-memory arbiter.
// The requester uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_sign;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (priority) and the loader.
// Defining DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     core,
  dmem_arbiter_if.slave     ldr,
  input  logic              ldr_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_core_grants,
  output logic [31:0]       stat_ldr_grants,
  output logic [31:0]       stat_conflicts
`endif
);
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Index 0 is the core, index 1 the loader.
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [1:0]        req_sign;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [31:0]       req_wdata [2];
  logic [1:0]        req_size  [2];
  logic [1:0]        grant;
  logic              sel;
  logic              sel_mis;

  logic              rsp_valid_q [2];
  logic              rsp_valid_d [2];
  logic              rsp_err_q   [2];
  logic              rsp_err_d   [2];
  logic [31:0]       rsp_rdata_q [2];
  logic [31:0]       rsp_rdata_d [2];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return (size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00) || (size == 2'b11);
  endfunction

  assign req_valid    = {ldr.req_valid, core.req_valid};
  assign req_write    = {ldr.req_write, core.req_write};
  assign req_sign     = {ldr.req_sign,  core.req_sign};
  assign req_addr[0]  = core.req_addr;
  assign req_addr[1]  = ldr.req_addr;
  assign req_wdata[0] = core.req_wdata;
  assign req_wdata[1] = ldr.req_wdata;
  assign req_size[0]  = core.req_size;
  assign req_size[1]  = ldr.req_size;

  always_comb begin
    grant      = 2'b00;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        // The cycle in which lock drops still belongs to the loader.
        grant[1] = req_valid[1];
        if (!ldr_lock) state_d = ST_ARB;
      end else begin
        if (req_valid[1] && (wait_cnt_q == WAIT_MAX || !req_valid[0])) grant[1] = 1'b1;
        else                                                            grant[0] = req_valid[0];
        if (grant[1] && ldr_lock) state_d = ST_LOCKED;
      end
    end
    if (!req_valid[1] || grant[1])                wait_cnt_d = '0;
    else if (grant[0] && wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign sel     = grant[1];
  assign sel_mis = misaligned(req_size[sel], req_addr[sel][1:0]);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_size  = '0;
    mem_sign  = 1'b0;
    if (grant != 2'b00) begin
      mem_addr  = req_addr[sel];
      mem_we    = req_write[sel] && !sel_mis;
      mem_wdata = req_wdata[sel];
      mem_size  = req_size[sel];
      mem_sign  = req_sign[sel];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      always_comb begin
        rsp_valid_d[gi] = grant[gi];
        rsp_err_d[gi]   = grant[gi] && sel_mis;
        rsp_rdata_d[gi] = (grant[gi] && !req_write[gi] && !sel_mis) ? mem_rdata : 32'd0;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_valid_q[gi] <= 1'b0;
          rsp_err_q[gi]   <= 1'b0;
          rsp_rdata_q[gi] <= 32'd0;
        end else begin
          rsp_valid_q[gi] <= rsp_valid_d[gi];
          rsp_err_q[gi]   <= rsp_err_d[gi];
          rsp_rdata_q[gi] <= rsp_rdata_d[gi];
        end
      end
    end
  endgenerate

  // Responses are masked while reset is held so every output reads 0 in that cycle.
  assign core.req_ready = grant[0];
  assign core.rsp_valid = rsp_valid_q[0] && !reset;
  assign core.rsp_err   = rsp_err_q[0] && !reset;
  assign core.rsp_rdata = reset ? 32'd0 : rsp_rdata_q[0];
  assign ldr.req_ready  = grant[1];
  assign ldr.rsp_valid  = rsp_valid_q[1] && !reset;
  assign ldr.rsp_err    = rsp_err_q[1] && !reset;
  assign ldr.rsp_rdata  = reset ? 32'd0 : rsp_rdata_q[1];

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_q, stat_core_d;
  logic [31:0] stat_ldr_q,  stat_ldr_d;
  logic [31:0] stat_conf_q, stat_conf_d;

  always_comb begin
    stat_core_d = stat_core_q;
    stat_ldr_d  = stat_ldr_q;
    stat_conf_d = stat_conf_q;
    if (grant[0] && stat_core_q != '1)            stat_core_d = stat_core_q + 32'd1;
    if (grant[1] && stat_ldr_q != '1)             stat_ldr_d  = stat_ldr_q + 32'd1;
    if (req_valid == 2'b11 && stat_conf_q != '1) stat_conf_d = stat_conf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_core_q <= '0;
      stat_ldr_q  <= '0;
      stat_conf_q <= '0;
    end else begin
      stat_core_q <= stat_core_d;
      stat_ldr_q  <= stat_ldr_d;
      stat_conf_q <= stat_conf_d;
    end
  end

  assign stat_core_grants = stat_core_q;
  assign stat_ldr_grants  = stat_ldr_q;
  assign stat_conflicts   = stat_conf_q;
`endif
endmodule
